// File: rtl/bool_sweep_checker.sv
// Sweeps an N_IN-bit input vector through every combination and holds each one for HOLD cycles.
// On the last cycle of each hold window, dut_y is compared against a serially loaded truth table.
module bool_sweep_checker #(
    parameter int unsigned N_IN = 3,
    parameter int unsigned HOLD = 10
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_tt_load_en,
    input  logic            i_tt_load_bit,
    input  logic            i_dut_y,
    output logic [N_IN-1:0] o_vec_out,
    output logic            o_vec_valid,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [N_IN:0]   o_err_count,
    output logic [N_IN-1:0] o_first_err_vec,
    output logic            o_first_err_valid
);

    localparam int unsigned NVEC = 1 << N_IN;
    localparam int unsigned HW   = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {StIdle, StApply, StDone} state_e;

    state_e          r_state_q, w_state_d;
    logic [N_IN-1:0] r_vec_q, w_vec_d;
    logic [HW-1:0]   r_hold_q, w_hold_d;
    logic [N_IN:0]   r_err_q, w_err_d;
    logic [N_IN-1:0] r_fvec_q, w_fvec_d;
    logic            r_fvld_q, w_fvld_d;
    logic [NVEC-1:0] r_tt_q, w_tt_d;
    logic            w_sample;
    logic            w_mismatch;

    assign w_sample   = (r_hold_q == HW'(HOLD - 1));
    assign w_mismatch = (i_dut_y != r_tt_q[r_vec_q]);

    always_comb begin
        w_state_d = r_state_q;
        w_vec_d   = r_vec_q;
        w_hold_d  = r_hold_q;
        w_err_d   = r_err_q;
        w_fvec_d  = r_fvec_q;
        w_fvld_d  = r_fvld_q;
        w_tt_d    = r_tt_q;
        unique case (r_state_q)
            StIdle, StDone: begin
                // start takes priority; a same-cycle load bit is dropped
                if (i_start) begin
                    w_state_d = StApply;
                    w_vec_d   = '0;
                    w_hold_d  = '0;
                    w_err_d   = '0;
                    w_fvec_d  = '0;
                    w_fvld_d  = 1'b0;
                end else if (i_tt_load_en) begin
                    w_tt_d = {i_tt_load_bit, r_tt_q[NVEC-1:1]};
                end
            end
            StApply: begin
                if (i_abort) begin
                    w_state_d = StIdle;
                    w_vec_d   = '0;
                    w_hold_d  = '0;
                end else begin
                    w_hold_d = r_hold_q + HW'(1);
                    if (w_sample) begin
                        if (w_mismatch) begin
                            w_err_d = r_err_q + (N_IN + 1)'(1);
                            if (!r_fvld_q) begin
                                w_fvec_d = r_vec_q;
                                w_fvld_d = 1'b1;
                            end
                        end
                        w_hold_d = '0;
                        if (r_vec_q == N_IN'(NVEC - 1)) begin
                            w_state_d = StDone;
                            w_vec_d   = '0;
                        end else begin
                            w_vec_d = r_vec_q + N_IN'(1);
                        end
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q <= StIdle;
            r_vec_q   <= '0;
            r_hold_q  <= '0;
            r_err_q   <= '0;
            r_fvec_q  <= '0;
            r_fvld_q  <= 1'b0;
            r_tt_q    <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_vec_q   <= w_vec_d;
            r_hold_q  <= w_hold_d;
            r_err_q   <= w_err_d;
            r_fvec_q  <= w_fvec_d;
            r_fvld_q  <= w_fvld_d;
            r_tt_q    <= w_tt_d;
        end
    end

    assign o_vec_out         = r_vec_q;
    assign o_vec_valid       = (r_state_q == StApply);
    assign o_busy            = (r_state_q == StApply);
    assign o_done            = (r_state_q == StDone);
    assign o_pass            = (r_state_q == StDone) && (r_err_q == '0);
    assign o_err_count       = r_err_q;
    assign o_first_err_vec   = r_fvec_q;
    assign o_first_err_valid = r_fvld_q;

endmodule

// File: tb/tb_bool_sweep_checker.sv
// Randomised bench for bool_sweep_checker: instance 0 is N_IN=3/HOLD=10, instance 1 is N_IN=4/HOLD=1.
// Expected results come from a truth-table comparison model kept in the bench.
module tb_bool_sweep_checker;

    logic clk;
    logic rst_n[2], start[2], abort[2], ld_en[2], ld_bit[2], y[2];
    logic busy[2], vld[2], done[2], pass[2], fevv[2];
    logic [15:0] fn[2], m_tt[2];
    logic [2:0] a_vec, a_fev;
    logic [3:0] a_err;
    logic [3:0] b_vec, b_fev;
    logic [4:0] b_err;
    int vec[2], fev[2], err[2];
    int n_checks, n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign vec[0] = int'(a_vec);
    assign vec[1] = int'(b_vec);
    assign fev[0] = int'(a_fev);
    assign fev[1] = int'(b_fev);
    assign err[0] = int'(a_err);
    assign err[1] = int'(b_err);
    assign y[0]   = fn[0][a_vec];
    assign y[1]   = fn[1][b_vec];

    bool_sweep_checker #(.N_IN(3), .HOLD(10)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_start(start[0]), .i_abort(abort[0]),
        .i_tt_load_en(ld_en[0]), .i_tt_load_bit(ld_bit[0]), .i_dut_y(y[0]),
        .o_vec_out(a_vec), .o_vec_valid(vld[0]), .o_busy(busy[0]), .o_done(done[0]),
        .o_pass(pass[0]), .o_err_count(a_err), .o_first_err_vec(a_fev),
        .o_first_err_valid(fevv[0])
    );

    bool_sweep_checker #(.N_IN(4), .HOLD(1)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_start(start[1]), .i_abort(abort[1]),
        .i_tt_load_en(ld_en[1]), .i_tt_load_bit(ld_bit[1]), .i_dut_y(y[1]),
        .o_vec_out(b_vec), .o_vec_valid(vld[1]), .o_busy(busy[1]), .o_done(done[1]),
        .o_pass(pass[1]), .o_err_count(b_err), .o_first_err_vec(b_fev),
        .o_first_err_valid(fevv[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int nvec(input int s);
        return (s == 0) ? 8 : 16;
    endfunction

    function automatic int hold(input int s);
        return (s == 0) ? 10 : 1;
    endfunction

    // Count mismatching vectors among the first n and report the lowest one (-1 if none).
    function automatic void model(input logic [15:0] t, input logic [15:0] f, input int n,
                                  output int cnt, output int first);
        cnt   = 0;
        first = -1;
        for (int v = 0; v < n; v++) begin
            if (t[v] != f[v]) begin
                cnt++;
                if (first < 0) first = v;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input int s);
        chk("z_vec", vec[s], 0);
        chk("z_flags", int'({busy[s], vld[s], done[s], pass[s], fevv[s]}), 0);
        chk("z_err", err[s], 0);
        chk("z_fev", fev[s], 0);
    endtask

    task automatic check_result(input int s, input logic [15:0] f, input int n);
        int cnt, first;
        model(m_tt[s], f, n, cnt, first);
        chk("r_err", err[s], cnt);
        chk("r_fev", fev[s], (first < 0) ? 0 : first);
        chk("r_fevv", int'(fevv[s]), (first < 0) ? 0 : 1);
    endtask

    task automatic load(input int s, input logic [15:0] v);
        for (int i = 0; i < nvec(s); i++) begin
            ld_bit[s] = v[i];
            ld_en[s]  = 1'b1;
            tick();
        end
        ld_en[s] = 1'b0;
        m_tt[s]  = (nvec(s) == 8) ? (v & 16'h00FF) : v;
    endtask

    task automatic sweep(input int s, input logic [15:0] f, input bit inject);
        int total;
        total    = nvec(s) * hold(s);
        fn[s]    = f;
        start[s] = 1'b1;
        tick();
        start[s] = 1'b0;
        for (int c = 0; c < total; c++) begin
            chk("sw_vec", vec[s], c / hold(s));
            chk("sw_state", int'({busy[s], vld[s], done[s]}), 6);
            if (c == 0) chk("sw_clr", int'({fevv[s], err[s][4:0]}), 0);
            // start and load pulses mid-sweep must be ignored
            if (inject && c == total / 2) begin
                start[s]  = 1'b1;
                ld_en[s]  = 1'b1;
                ld_bit[s] = ~m_tt[s][0];
            end
            tick();
            start[s] = 1'b0;
            ld_en[s] = 1'b0;
        end
        chk("d_state", int'({busy[s], vld[s], done[s]}), 1);
        chk("d_vec", vec[s], 0);
        check_result(s, f, nvec(s));
        chk("d_pass", int'(pass[s]), (err[s] == 0 && (m_tt[s] & ((nvec(s) == 8) ? 16'h00FF : 16'hFFFF))
                                      == (f & ((nvec(s) == 8) ? 16'h00FF : 16'hFFFF))) ? 1 : 0);
        abort[s] = 1'b1;
        tick();
        abort[s] = 1'b0;
        chk("d_hold", int'({done[s], busy[s]}), 2);
    endtask

    task automatic abort_sweep(input int s, input logic [15:0] f, input int at);
        fn[s]    = f;
        start[s] = 1'b1;
        tick();
        start[s] = 1'b0;
        repeat (at) tick();
        abort[s] = 1'b1;
        tick();
        abort[s] = 1'b0;
        chk("ab_state", int'({busy[s], vld[s], done[s]}), 0);
        chk("ab_vec", vec[s], 0);
        check_result(s, f, at / hold(s));
    endtask

    task automatic reset_mid(input int s, input int at);
        start[s] = 1'b1;
        tick();
        start[s] = 1'b0;
        repeat (at) tick();
        chk("rs_busy", int'(busy[s]), 1);
        #2 rst_n[s] = 1'b0;
        #1 check_zero(s);
        m_tt[s] = '0;
        @(negedge clk);
        rst_n[s] = 1'b1;
        tick();
    endtask

    initial begin
        logic [15:0] t, f;
        n_checks = 0;
        n_fail   = 0;
        for (int s = 0; s < 2; s++) begin
            rst_n[s] = 1'b1; start[s] = 1'b0; abort[s] = 1'b0;
            ld_en[s] = 1'b0; ld_bit[s] = 1'b0; fn[s] = '0; m_tt[s] = '0;
        end
        #1;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        repeat (2) tick();
        check_zero(0);
        check_zero(1);
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        tick();

        load(0, 16'h00E8);
        sweep(0, 16'h00E8, 1'b0);
        sweep(0, 16'h0000, 1'b0);
        load(0, 16'h0000);
        sweep(0, 16'h00FF, 1'b0);
        sweep(0, 16'h0000, 1'b0);

        load(0, 16'h00E8);
        abort_sweep(0, 16'h0000, 25);
        sweep(0, 16'h0000, 1'b0);
        abort_sweep(0, 16'h00FF, 19);

        reset_mid(0, 37);
        sweep(0, 16'h00E8, 1'b0);

        t = 16'($urandom);
        load(1, t);
        sweep(1, 16'($urandom), 1'b1);
        sweep(1, t, 1'b1);

        for (int it = 0; it < 6; it++) begin
            t = 16'($urandom);
            f = 16'($urandom);
            load(0, t);
            if ($urandom_range(0, 1) == 1) sweep(0, f, 1'b1);
            else abort_sweep(0, f, int'($urandom_range(1, 79)));
            t = 16'($urandom);
            f = 16'($urandom);
            load(1, t);
            if ($urandom_range(0, 1) == 1) sweep(1, f, 1'b1);
            else abort_sweep(1, f, int'($urandom_range(1, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bool_sweep_checker.md
# bool_sweep_checker

Parametrised self-checking stimulus engine for N-input Boolean functions. It steps an input vector through all 2^N_IN combinations and holds each one for a programmable number of cycles. At the end of each hold window it compares the device output against a serially loaded expected truth table, then reports a mismatch count, the first failing vector and pass/done status. It sits beside a combinational Boolean block in simulation or on-chip BIST and replaces hand-written vector lists with a synthesizable sweep.

## Interface
- N_IN, 3, number of function inputs (1..8); sweep length 2^N_IN vectors
- HOLD, 10, cycles each vector is held (>=1); sample taken on last cycle of window
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a sweep (accepted in IDLE or DONE)
- abort  in  1  cancel sweep in progress (honoured in APPLY only)
- tt_load_en  in  1  shift one truth-table bit per cycle (accepted in IDLE or DONE)
- tt_load_bit  in  1  serial truth-table data; first bit loaded ends at index 0 after 2^N_IN loads
- dut_y  in  1  output of function under test
- vec_out  out  N_IN  current input vector to the device
- vec_valid  out  1  high while vec_out is being applied
- busy  out  1  sweep in progress
- done  out  1  sweep complete; level, held until next start
- pass  out  1  err_count==0; meaningful only while done=1
- err_count  out  N_IN+1  number of mismatching vectors (max 2^N_IN)
- first_err_vec  out  N_IN  lowest-time failing vector
- first_err_valid  out  1  first_err_vec holds a captured value

## Operation
- States: IDLE, APPLY, DONE. Reset enters IDLE.
- Reset values: vec_out=0, vec_valid=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, first_err_valid=0, truth table=0, hold counter=0.
- Truth-table load (IDLE/DONE, tt_load_en=1): tt <= {tt_load_bit, tt[2^N_IN-1:1]}. Ignored in APPLY.
- IDLE/DONE + start=1 -> APPLY:
  - vec_out=0, hold_cnt=0, err_count=0, first_err_valid=0, first_err_vec=0.
  - busy=1, vec_valid=1, done=0, pass=0.
  - start and tt_load_en in the same cycle: start wins and the load bit is dropped.
- APPLY, each cycle: hold_cnt++.
- APPLY, when hold_cnt==HOLD-1: sample dut_y and compare with tt[vec_out].
  - On mismatch: err_count++. If first_err_valid=0, capture first_err_vec=vec_out and set first_err_valid=1.
  - If vec_out==2^N_IN-1 -> DONE. Otherwise vec_out++ and hold_cnt=0.
- APPLY + abort=1 -> IDLE: busy=0, vec_valid=0, vec_out=0, done=0. Counters keep their partial values. abort has priority over a same-cycle sample.
- DONE: done=1, busy=0, vec_valid=0, vec_out=0, pass=(err_count==0). Stays in DONE until the next start.
- start during APPLY is ignored. abort outside APPLY is ignored.
- Width rules:
  - err_count saturates naturally at 2^N_IN, so no overflow is possible.
  - hold_cnt width is clog2(HOLD), minimum 1 bit.

## Timing
- start sampled at edge k: vec_out=0 and vec_valid=1 are visible after edge k (1-cycle latency).
- Vector i is driven during cycles k+i*HOLD+1 .. k+(i+1)*HOLD. dut_y is sampled at edge k+(i+1)*HOLD.
- done rises after edge k+2^N_IN*HOLD. Total sweep is 2^N_IN*HOLD cycles.
- dut_y must be settled within HOLD-1 cycles of a vector change. HOLD=1 samples in the same cycle the vector is applied.
- Async reset mid-sweep: all outputs and the truth table clear immediately, without waiting for clk. The block returns to IDLE.

## Test plan
- N_IN=3, HOLD=10, load 8'hE8 (majority), dut_y from a majority model, pulse start -> done at start+80 cycles, err_count=0, pass=1, first_err_valid=0.
- Same table, dut_y stuck at 0 -> err_count=4, first_err_vec=3, first_err_valid=1, pass=0.
- Load 8'h00, dut_y=1 always -> err_count=8, first_err_vec=0. Pulse start again with dut_y=0 -> err_count=0, pass=1, and first_err_valid clears at start.
- abort 25 cycles after start (vector 2 applied) -> next cycle busy=0, vec_valid=0, vec_out=0, done=0. A new start then completes normally.
- rst_n low at start+37 -> outputs zero asynchronously. A subsequent sweep with no reload compares against an all-zero table.
- N_IN=4, HOLD=1 -> done 16 cycles after start. Pulsing start and tt_load_en mid-sweep changes neither timing nor the truth table.
